friscv_rv32i_issue_ctrl: RTL and testbench

In-order, single-issue controller between the instruction fetch stage and the execution units.
- Latches one fetched instruction and drives it into the RV32I decoder.
- Classifies the decoder flags and dispatches the instruction to the processing unit (ALU/memory) or the control unit (jumps, branches, AUIPC, SYSTEM).
- Serializes control-flow instructions, flushes fetch on taken redirects, raises traps on illegal encodings, and counts retired instructions.

---
 rtl/friscv_rv32i_issue_ctrl.sv | 163 ++++++++++++++++
 tb/tb_friscv_rv32i_issue_ctrl.sv | 478 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/friscv_rv32i_issue_ctrl.sv
// In-order single-issue controller between fetch and the execution units.
// Dispatches to processing/control units, serializes jumps, traps, counts retires.
`timescale 1ns/1ps

module friscv_rv32i_issue_ctrl #(
    parameter int XLEN      = 32,
    parameter int INSTRET_W = 64
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 inst_valid,
    output logic                 inst_ready,
    input  logic [XLEN-1:0]      inst_data,
    input  logic [XLEN-1:0]      inst_pc,
    output logic [XLEN-1:0]      dec_instruction,
    input  logic                 dec_auipc,
    input  logic                 dec_jal,
    input  logic                 dec_jalr,
    input  logic                 dec_branching,
    input  logic                 dec_system,
    input  logic                 dec_processing,
    input  logic                 dec_inst_error,
    output logic                 proc_valid,
    input  logic                 proc_ready,
    output logic                 ctrl_valid,
    input  logic                 ctrl_ready,
    input  logic                 ctrl_done,
    input  logic                 ctrl_flush,
    output logic [XLEN-1:0]      issue_instr,
    output logic [XLEN-1:0]      issue_pc,
    output logic                 flush,
    output logic                 trap_valid,
    output logic [XLEN-1:0]      trap_pc,
    input  logic                 trap_ack,
    output logic [INSTRET_W-1:0] instret,
    output logic                 busy
);

    typedef enum logic [2:0] {
        IDLE,
        LOADED,
        WAIT_CTRL,
        FLUSH,
        TRAP
    } state_t;

    state_t                state_q, state_d;
    logic [XLEN-1:0]       instr_q, instr_d;
    logic [XLEN-1:0]       pc_q, pc_d;
    logic [INSTRET_W-1:0]  instret_q, instret_d;

    logic cls_ctl;
    logic cls_err;
    logic cls_proc;
    logic cls_wait;

    logic ready_c;
    logic proc_v_c;
    logic ctrl_v_c;
    logic flush_c;
    logic trap_c;

    // Classify the decoder flags; control-flow wins over processing.
    assign cls_ctl  = dec_auipc | dec_jal | dec_jalr
                    | dec_branching | dec_system;
    assign cls_err  = dec_inst_error | ~(cls_ctl | dec_processing);
    assign cls_proc = dec_processing & ~cls_ctl;
    assign cls_wait = dec_jal | dec_jalr | dec_branching;

    // Next-state, dispatch handshakes and retire counting.
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        pc_d      = pc_q;
        instret_d = instret_q;
        ready_c   = 1'b0;
        proc_v_c  = 1'b0;
        ctrl_v_c  = 1'b0;
        flush_c   = 1'b0;
        trap_c    = 1'b0;
        case (state_q)
            IDLE: begin
                ready_c = 1'b1;
                if (inst_valid) begin
                    instr_d = inst_data;
                    pc_d    = inst_pc;
                    state_d = LOADED;
                end
            end
            LOADED: begin
                if (cls_err) begin
                    trap_c  = 1'b1;
                    state_d = TRAP;
                end else if (cls_proc) begin
                    proc_v_c = 1'b1;
                    if (proc_ready) begin
                        instret_d = instret_q + INSTRET_W'(1);
                        ready_c   = 1'b1;
                        if (inst_valid) begin
                            instr_d = inst_data;
                            pc_d    = inst_pc;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end else begin
                    ctrl_v_c = 1'b1;
                    if (ctrl_ready) begin
                        instret_d = instret_q + INSTRET_W'(1);
                        state_d   = cls_wait ? WAIT_CTRL : IDLE;
                    end
                end
            end
            WAIT_CTRL: begin
                if (ctrl_done) begin
                    state_d = ctrl_flush ? FLUSH : IDLE;
                end
            end
            FLUSH: begin
                flush_c = 1'b1;
                state_d = IDLE;
            end
            TRAP: begin
                trap_c = 1'b1;
                if (trap_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, instruction/PC latch and retire counter.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            instr_q   <= '0;
            pc_q      <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            instret_q <= instret_d;
        end
    end

    // Ready is masked while reset is held so every output reads 0.
    assign inst_ready      = ready_c & aresetn;
    assign dec_instruction = instr_q;
    assign issue_instr     = instr_q;
    assign issue_pc        = pc_q;
    assign proc_valid      = proc_v_c;
    assign ctrl_valid      = ctrl_v_c;
    assign flush           = flush_c;
    assign trap_valid      = trap_c;
    assign trap_pc         = trap_c ? pc_q : '0;
    assign instret         = instret_q;
    assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_friscv_rv32i_issue_ctrl.sv
// Bench for friscv_rv32i_issue_ctrl: vector table, corner sequences,
// and random traffic against a cycle-level behavioural model.
`timescale 1ns/1ps

module tb_friscv_rv32i_issue_ctrl;

    localparam int XLEN = 32;
    localparam int IW   = 8;

    localparam int K_PROC = 0;
    localparam int K_CTL  = 1;
    localparam int K_JMP  = 2;
    localparam int K_BAD  = 3;

    logic            aclk = 1'b0;
    logic            aresetn;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst_data;
    logic [XLEN-1:0] inst_pc;
    logic [XLEN-1:0] dec_instruction;
    logic            dec_auipc;
    logic            dec_jal;
    logic            dec_jalr;
    logic            dec_branching;
    logic            dec_system;
    logic            dec_processing;
    logic            dec_inst_error;
    logic            proc_valid;
    logic            proc_ready;
    logic            ctrl_valid;
    logic            ctrl_ready;
    logic            ctrl_done;
    logic            ctrl_flush;
    logic [XLEN-1:0] issue_instr;
    logic [XLEN-1:0] issue_pc;
    logic            flush;
    logic            trap_valid;
    logic [XLEN-1:0] trap_pc;
    logic            trap_ack;
    logic [IW-1:0]   instret;
    logic            busy;

    logic            extra_proc;
    logic            force_err;

    always #5 aclk = ~aclk;

    friscv_rv32i_issue_ctrl #(
        .XLEN      (XLEN),
        .INSTRET_W (IW)
    ) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc),
        .dec_instruction (dec_instruction),
        .dec_auipc       (dec_auipc),
        .dec_jal         (dec_jal),
        .dec_jalr        (dec_jalr),
        .dec_branching   (dec_branching),
        .dec_system      (dec_system),
        .dec_processing  (dec_processing),
        .dec_inst_error  (dec_inst_error),
        .proc_valid      (proc_valid),
        .proc_ready      (proc_ready),
        .ctrl_valid      (ctrl_valid),
        .ctrl_ready      (ctrl_ready),
        .ctrl_done       (ctrl_done),
        .ctrl_flush      (ctrl_flush),
        .issue_instr     (issue_instr),
        .issue_pc        (issue_pc),
        .flush           (flush),
        .trap_valid      (trap_valid),
        .trap_pc         (trap_pc),
        .trap_ack        (trap_ack),
        .instret         (instret),
        .busy            (busy)
    );

    // Stand-in RV32I decoder driven by the registered instruction.
    logic [6:0] opc;
    assign opc            = dec_instruction[6:0];
    assign dec_auipc      = (opc == 7'h17);
    assign dec_jal        = (opc == 7'h6F);
    assign dec_jalr       = (opc == 7'h67);
    assign dec_branching  = (opc == 7'h63);
    assign dec_system     = (opc == 7'h73);
    assign dec_processing = (opc == 7'h37) || (opc == 7'h03)
                         || (opc == 7'h23) || (opc == 7'h13)
                         || (opc == 7'h33) || (opc == 7'h0F)
                         || extra_proc;
    assign dec_inst_error = force_err;

    int n_chk = 0;
    int n_err = 0;

    // Behavioural model state.
    bit              m_full;
    bit              m_wait;
    bit              m_flush;
    bit              m_trap;
    logic [XLEN-1:0] m_instr;
    logic [XLEN-1:0] m_pc;
    int unsigned     m_cnt;

    bit s_pv;
    bit s_cv;
    bit s_ir;
    bit s_fl;

    typedef struct {
        logic [31:0] ins;
        bit          pv;
        bit          cv;
        bit          tv;
        bit          stay;
    } vec_t;

    vec_t tbl[12];
    logic [31:0] pool[12];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual %0h required %0h", nm, act, req);
        end
    endtask

    function automatic int kind(input logic [31:0] ins);
        int k;
        case (ins[6:0])
            7'h37, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F: k = K_PROC;
            7'h17, 7'h73:                             k = K_CTL;
            7'h6F, 7'h67, 7'h63:                      k = K_JMP;
            default:                                  k = K_BAD;
        endcase
        if (force_err)
            k = K_BAD;
        else if (extra_proc && k == K_BAD)
            k = K_PROC;
        return k;
    endfunction

    task automatic model_reset();
        m_full  = 0;
        m_wait  = 0;
        m_flush = 0;
        m_trap  = 0;
        m_instr = '0;
        m_pc    = '0;
        m_cnt   = 0;
    endtask

    // Called just after a falling edge with inputs applied; compares,
    // advances the model across the next rising edge, returns at the
    // following falling edge.
    task automatic cyc();
        int k;
        bit ep, ec, et, er, eb;
        #1;
        k  = kind(m_instr);
        eb = m_full || m_wait || m_flush || m_trap;
        ep = m_full && (k == K_PROC);
        ec = m_full && (k == K_CTL || k == K_JMP);
        et = m_trap || (m_full && k == K_BAD);
        er = !eb || (ep && proc_ready);
        chk("inst_ready", 64'(inst_ready), 64'(er));
        chk("proc_valid", 64'(proc_valid), 64'(ep));
        chk("ctrl_valid", 64'(ctrl_valid), 64'(ec));
        chk("trap_valid", 64'(trap_valid), 64'(et));
        chk("flush", 64'(flush), 64'(m_flush));
        chk("busy", 64'(busy), 64'(eb));
        chk("instret", 64'(instret), 64'(m_cnt % 256));
        chk("issue_instr", 64'(issue_instr), 64'(m_instr));
        chk("issue_pc", 64'(issue_pc), 64'(m_pc));
        chk("dec_instruction", 64'(dec_instruction), 64'(m_instr));
        if (et)
            chk("trap_pc", 64'(trap_pc), 64'(m_pc));
        s_pv = proc_valid;
        s_cv = ctrl_valid;
        s_ir = inst_ready;
        s_fl = flush;
        if (m_trap) begin
            if (trap_ack) m_trap = 0;
        end else if (m_flush) begin
            m_flush = 0;
        end else if (m_wait) begin
            if (ctrl_done) begin
                m_wait  = 0;
                m_flush = ctrl_flush;
            end
        end else if (m_full) begin
            if (k == K_BAD) begin
                m_full = 0;
                m_trap = 1;
            end else if (k == K_PROC) begin
                if (proc_ready) begin
                    m_cnt++;
                    if (inst_valid) begin
                        m_instr = inst_data;
                        m_pc    = inst_pc;
                    end else begin
                        m_full = 0;
                    end
                end
            end else if (ctrl_ready) begin
                m_cnt++;
                m_full = 0;
                m_wait = (k == K_JMP);
            end
        end else if (inst_valid) begin
            m_full  = 1;
            m_instr = inst_data;
            m_pc    = inst_pc;
        end
        @(posedge aclk);
        @(negedge aclk);
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
        inst_valid = 1;
        inst_data  = ins;
        inst_pc    = pc;
        cyc();
        inst_valid = 0;
    endtask

    task automatic quiet();
        inst_valid = 0;
        proc_ready = 0;
        ctrl_ready = 0;
        ctrl_done  = 0;
        ctrl_flush = 0;
        trap_ack   = 0;
    endtask

    initial begin
        int pv_cnt, cv_cnt, fl_cnt, drops;
        int unsigned base;

        tbl[0]  = '{32'h00500093, 1, 0, 0, 0};
        tbl[1]  = '{32'h00C12403, 1, 0, 0, 0};
        tbl[2]  = '{32'h00112023, 1, 0, 0, 0};
        tbl[3]  = '{32'h000012B7, 1, 0, 0, 0};
        tbl[4]  = '{32'h002081B3, 1, 0, 0, 0};
        tbl[5]  = '{32'h00208463, 0, 1, 0, 1};
        tbl[6]  = '{32'h008000EF, 0, 1, 0, 1};
        tbl[7]  = '{32'h000080E7, 0, 1, 0, 1};
        tbl[8]  = '{32'h00000297, 0, 1, 0, 0};
        tbl[9]  = '{32'h00000073, 0, 1, 0, 0};
        tbl[10] = '{32'hFFFFFFFF, 0, 0, 1, 1};
        tbl[11] = '{32'h00000000, 0, 0, 1, 1};
        for (int i = 0; i < 12; i++)
            pool[i] = tbl[i].ins;

        aresetn    = 0;
        extra_proc = 0;
        force_err  = 0;
        inst_data  = '0;
        inst_pc    = '0;
        quiet();
        model_reset();

        #3;
        chk("rst_inst_ready", 64'(inst_ready), 0);
        chk("rst_proc_valid", 64'(proc_valid), 0);
        chk("rst_ctrl_valid", 64'(ctrl_valid), 0);
        chk("rst_trap_valid", 64'(trap_valid), 0);
        chk("rst_flush", 64'(flush), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_instret", 64'(instret), 0);
        chk("rst_issue_instr", 64'(issue_instr), 0);
        chk("rst_issue_pc", 64'(issue_pc), 0);
        chk("rst_trap_pc", 64'(trap_pc), 0);
        @(negedge aclk);
        aresetn = 1;

        // Vector table: one instruction each, units always ready.
        for (int i = 0; i < 12; i++) begin
            quiet();
            issue(tbl[i].ins, 32'h1000 + 32'(i * 4));
            proc_ready = 1;
            ctrl_ready = 1;
            #1;
            chk("tbl_proc_valid", 64'(proc_valid), 64'(tbl[i].pv));
            chk("tbl_ctrl_valid", 64'(ctrl_valid), 64'(tbl[i].cv));
            chk("tbl_trap_valid", 64'(trap_valid), 64'(tbl[i].tv));
            cyc();
            #1;
            chk("tbl_stay_busy", 64'(busy), 64'(tbl[i].stay));
            quiet();
            ctrl_done = 1;
            trap_ack  = 1;
            cyc();
            quiet();
            cyc();
        end

        // Back-to-back ALU stream.
        quiet();
        proc_ready = 1;
        base   = m_cnt;
        pv_cnt = 0;
        drops  = 0;
        inst_valid = 1;
        inst_data  = 32'h00500093; inst_pc = 32'h200;
        cyc(); pv_cnt += int'(s_pv); drops += int'(!s_ir);
        inst_data  = 32'h00108113; inst_pc = 32'h204;
        cyc(); pv_cnt += int'(s_pv); drops += int'(!s_ir);
        inst_data  = 32'h002081B3; inst_pc = 32'h208;
        cyc(); pv_cnt += int'(s_pv); drops += int'(!s_ir);
        inst_valid = 0;
        cyc(); pv_cnt += int'(s_pv); drops += int'(!s_ir);
        chk("b2b_proc_cycles", 64'(pv_cnt), 3);
        chk("b2b_ready_drops", 64'(drops), 0);
        chk("b2b_instret", 64'(instret), 64'((base + 3) % 256));

        // Backpressure on a load.
        quiet();
        issue(32'h00C12403, 32'h300);
        base = m_cnt;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("bp_issue_instr", 64'(issue_instr), 64'h00C12403);
        end
        proc_ready = 1;
        cyc();
        chk("bp_handshake", 64'(s_pv), 1);
        quiet();
        cyc();
        chk("bp_instret", 64'(instret), 64'((base + 1) % 256));

        // Taken branch with redirect three cycles after dispatch.
        quiet();
        issue(32'h00208463, 32'h400);
        ctrl_ready = 1;
        cv_cnt = 0;
        fl_cnt = 0;
        drops  = 0;
        cyc(); cv_cnt += int'(s_cv);
        quiet();
        for (int i = 0; i < 2; i++) begin
            cyc(); cv_cnt += int'(s_cv); drops += int'(s_ir);
        end
        ctrl_done  = 1;
        ctrl_flush = 1;
        cyc(); cv_cnt += int'(s_cv); drops += int'(s_ir);
        quiet();
        for (int i = 0; i < 3; i++) begin
            cyc(); fl_cnt += int'(s_fl); cv_cnt += int'(s_cv);
        end
        chk("br_ctrl_cycles", 64'(cv_cnt), 1);
        chk("br_ready_in_wait", 64'(drops), 0);
        chk("br_flush_pulses", 64'(fl_cnt), 1);
        chk("br_back_idle", 64'(s_ir), 1);

        // Not-taken branch; a done pulse in the dispatch cycle is ignored.
        quiet();
        issue(32'h00208463, 32'h500);
        ctrl_ready = 1;
        ctrl_done  = 1;
        ctrl_flush = 1;
        cyc();
        quiet();
        cyc();
        chk("nt_still_waiting", 64'(s_ir), 0);
        ctrl_done = 1;
        cyc();
        quiet();
        cyc();
        chk("nt_no_flush", 64'(s_fl), 0);
        chk("nt_idle", 64'(s_ir), 1);

        // AUIPC returns straight to idle.
        quiet();
        issue(32'h00000297, 32'h600);
        ctrl_ready = 1;
        cyc();
        quiet();
        cyc();
        chk("auipc_idle", 64'(s_ir), 1);

        // Illegal instruction traps and holds until acknowledged.
        quiet();
        base = m_cnt;
        issue(32'hFFFFFFFF, 32'h100);
        proc_ready = 1;
        ctrl_ready = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("ill_trap_pc", 64'(trap_pc), 64'h100);
            chk("ill_no_dispatch", 64'(s_pv | s_cv), 0);
        end
        trap_ack = 1;
        cyc();
        quiet();
        cyc();
        chk("ill_instret", 64'(instret), 64'(base % 256));
        chk("ill_idle", 64'(s_ir), 1);

        // Control class wins over a simultaneous processing flag.
        quiet();
        extra_proc = 1;
        issue(32'h00208463, 32'h700);
        #1;
        chk("ctlwin_ctrl", 64'(ctrl_valid), 1);
        chk("ctlwin_proc", 64'(proc_valid), 0);
        ctrl_ready = 1;
        cyc();
        quiet();
        ctrl_done = 1;
        cyc();
        quiet();
        extra_proc = 0;
        cyc();

        // Decoder error flag overrides a valid ALU encoding.
        force_err = 1;
        issue(32'h00500093, 32'h800);
        proc_ready = 1;
        #1;
        chk("err_trap", 64'(trap_valid), 1);
        chk("err_no_proc", 64'(proc_valid), 0);
        cyc();
        quiet();
        trap_ack = 1;
        cyc();
        quiet();
        force_err = 0;
        cyc();

        // Reset while a dispatch is stalled.
        issue(32'h00C12403, 32'h900);
        cyc();
        aresetn = 0;
        #1;
        chk("mrst_proc_valid", 64'(proc_valid), 0);
        chk("mrst_inst_ready", 64'(inst_ready), 0);
        chk("mrst_busy", 64'(busy), 0);
        chk("mrst_flush", 64'(flush), 0);
        chk("mrst_instret", 64'(instret), 0);
        chk("mrst_issue_instr", 64'(issue_instr), 0);
        model_reset();
        #1;
        aresetn = 1;
        #1;
        issue(32'h00500093, 32'hA00);
        proc_ready = 1;
        cyc();
        quiet();
        cyc();
        chk("mrst_retire", 64'(instret), 1);

        // Random traffic against the model; wraps the narrow counter.
        for (int n = 0; n < 3000; n++) begin
            inst_valid = ($urandom_range(0, 3) != 0);
            inst_data  = pool[$urandom_range(0, 11)];
            if (inst_data[6:0] != 7'h7F && inst_data != 32'h0)
                inst_data[19:12] = 8'($urandom);
            inst_pc    = $urandom & 32'hFFFF_FFFC;
            proc_ready = ($urandom_range(0, 2) != 0);
            ctrl_ready = ($urandom_range(0, 2) != 0);
            ctrl_done  = ($urandom_range(0, 3) == 0);
            ctrl_flush = 1'($urandom);
            trap_ack   = ($urandom_range(0, 2) == 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
